// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   DATA_WIDTH : width of one UART byte
//   NEWLINE    : byte that ends a message and releases the lock
//   arb_state_e: arbiter state type (idle / locked to one owner)
//   wrap_inc   : increment an index modulo a count
package uart_arb_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam logic [DATA_WIDTH-1:0] NEWLINE = 8'h0A;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    typedef enum logic [0:0] {
        StIdle   = ST_IDLE,
        StLocked = ST_LOCKED
    } arb_state_e;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 32'd0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin priority picker.
//   req       : request vector, one bit per requester
//   rr_ptr    : highest-priority index (must be < NUM_REQ)
//   winner    : first set index at or above rr_ptr, wrapping past NUM_REQ-1 to 0
//   any_valid : at least one request bit is set
module uart_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any_valid
);

    logic [ID_W:0] idx;

    always_comb begin
        winner    = '0;
        any_valid = |req;
        idx       = '0;
        // Walk from the farthest position back towards rr_ptr so the closest hit wins last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (idx >= (ID_W + 1)'(NUM_REQ)) begin
                idx = idx - (ID_W + 1)'(NUM_REQ);
            end
            if (req[idx[ID_W-1:0]]) begin
                winner = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates several byte requesters onto one UART transmit stream. A requester
// that wins with a non-newline byte keeps the stream until it sends a newline or
// stays idle for TIMEOUT cycles, so messages are never interleaved.
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   req_valid/ready/bits : per-requester byte handshake, requester i in bits [8i+7:8i]
//   serial_out_*         : registered single-entry output towards the UART sink
//   grant_id             : current or most recent owner
//   locked               : high while one requester holds the stream
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_bits,
    output logic                          serial_out_valid,
    input  logic                          serial_out_ready,
    output logic [DATA_WIDTH-1:0]         serial_out_bits,
    output logic [ID_W-1:0]               grant_id,
    output logic                          locked
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    arb_state_e            state_q, state_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [ID_W-1:0]       grant_q, grant_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_bits_q, out_bits_d;

    logic                  can_load;
    logic                  grant_en;
    logic                  accept;
    logic [ID_W-1:0]       sel;
    logic                  sel_valid;
    logic [DATA_WIDTH-1:0] sel_bits;
    logic [ID_W-1:0]       winner;
    logic                  any_valid;

    function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] idx);
        return ID_W'(wrap_inc(32'(idx), NUM_REQ));
    endfunction

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Handshake: while locked, grant_q is the owner.
    always_comb begin
        can_load  = !out_valid_q || serial_out_ready;
        sel       = (state_q == StIdle) ? winner : grant_q;
        grant_en  = can_load && !reset && ((state_q == StLocked) || any_valid);
        sel_valid = req_valid[sel];
        sel_bits  = req_bits[DATA_WIDTH*32'(sel) +: DATA_WIDTH];
        accept    = grant_en && sel_valid;
        req_ready = '0;
        if (grant_en) begin
            req_ready[sel] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        timer_d     = timer_q;
        grant_d     = grant_q;
        out_valid_d = out_valid_q;
        out_bits_d  = out_bits_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_bits_d  = sel_bits;
        end else if (serial_out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    grant_d = winner;
                    if (sel_bits == NEWLINE) begin
                        rr_ptr_d = ptr_after(winner);
                    end else begin
                        state_d = StLocked;
                        timer_d = '0;
                    end
                end
            end
            StLocked: begin
                // An accept outranks a timeout in the same cycle.
                if (accept) begin
                    if (sel_bits == NEWLINE) begin
                        state_d  = StIdle;
                        rr_ptr_d = ptr_after(grant_q);
                    end else begin
                        timer_d = '0;
                    end
                end else if (!req_valid[grant_q]) begin
                    // Only owner-idle cycles count; a sink stall holds the timer.
                    if (timer_q == TMR_LAST) begin
                        state_d  = StIdle;
                        rr_ptr_d = ptr_after(grant_q);
                        timer_d  = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            timer_q     <= '0;
            grant_q     <= '0;
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            timer_q     <= timer_d;
            grant_q     <= grant_d;
            out_valid_q <= out_valid_d;
            out_bits_q  <= out_bits_d;
        end
    end

    assign serial_out_valid = out_valid_q;
    assign serial_out_bits  = out_bits_q;
    assign grant_id         = grant_q;
    assign locked           = (state_q == StLocked);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT=4): a message-level
// model checked every cycle, plus hand-computed expectations per scenario.
module tb_uart_tx_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned TMO = 4;
    localparam logic [7:0]  NL  = 8'h0A;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*8-1:0] req_bits;
    logic           serial_out_valid;
    logic           serial_out_ready;
    logic [7:0]     serial_out_bits;
    logic [1:0]     grant_id;
    logic           locked;

    uart_tx_arbiter #(
        .NUM_REQ (N),
        .TIMEOUT (TMO)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_bits         (req_bits),
        .serial_out_valid (serial_out_valid),
        .serial_out_ready (serial_out_ready),
        .serial_out_bits  (serial_out_bits),
        .grant_id         (grant_id),
        .locked           (locked)
    );

    always #5 clock = ~clock;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- requester sources ----------------
    logic [7:0]   src_buf [N][16];
    int           src_len [N];
    int           src_pos [N];
    logic [N-1:0] en;
    logic [N-1:0] fire;

    task automatic set_src(input int i, input string s);
        src_len[i] = s.len();
        src_pos[i] = 0;
        for (int j = 0; j < s.len() && j < 16; j++) src_buf[i][j] = s[j];
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        en = '0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (en[i] && src_pos[i] < src_len[i]) begin
                req_valid[i]      = 1'b1;
                req_bits[i*8 +: 8] = src_buf[i][src_pos[i]];
            end else begin
                req_valid[i]      = 1'b0;
                req_bits[i*8 +: 8] = 8'h00;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) if (fire[i] === 1'b1) src_pos[i]++;
        drive();
    endtask

    // ---------------- behavioural model ----------------
    bit         m_locked = 1'b0;
    int         m_owner = 0;
    int         m_ptr = 0;
    int         m_idle = 0;
    int         m_grant = 0;
    bit         m_valid = 1'b0;
    logic [7:0] m_bits = 8'h00;

    function automatic int m_pick();
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (req_valid[idx] === 1'b1) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        int w;
        r = '0;
        if (reset || !(!m_valid || serial_out_ready)) return r;
        if (m_locked) begin
            r[m_owner] = 1'b1;
        end else begin
            w = m_pick();
            if (w >= 0) r[w] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_step();
        logic [N-1:0] r;
        int a;
        logic [7:0] b;
        if (reset) begin
            m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_idle = 0;
            m_grant = 0; m_valid = 1'b0; m_bits = 8'h00;
            return;
        end
        r = m_ready();
        a = -1;
        b = 8'h00;
        for (int i = 0; i < N; i++) if (r[i] && req_valid[i] === 1'b1) a = i;
        if (a >= 0) b = req_bits[a*8 +: 8];
        if (a >= 0) begin
            m_valid = 1'b1;
            m_bits  = b;
        end else if (serial_out_ready) begin
            m_valid = 1'b0;
        end
        if (!m_locked) begin
            if (a >= 0) begin
                m_grant = a;
                if (b == NL) begin
                    m_ptr = (a + 1) % N;
                end else begin
                    m_locked = 1'b1;
                    m_owner  = a;
                    m_idle   = 0;
                end
            end
        end else begin
            if (a >= 0) begin
                if (b == NL) begin
                    m_locked = 1'b0;
                    m_ptr    = (m_owner + 1) % N;
                end else begin
                    m_idle = 0;
                end
            end else if (req_valid[m_owner] !== 1'b1) begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_locked = 1'b0;
                    m_ptr    = (m_owner + 1) % N;
                    m_idle   = 0;
                end
            end
        end
    endtask

    always @(posedge clock) model_step();

    // ---------------- compare and logging ----------------
    logic [7:0]   out_b [$];
    int           out_g [$];
    int           out_t [$];
    logic         lk [$];
    logic [N-1:0] rq [$];

    always @(negedge clock) begin
        fire = req_valid & req_ready;
        cyc++;
        if (chk_en) begin
            check("req_ready", 32'(req_ready), 32'(m_ready()));
            check("serial_out_valid", 32'(serial_out_valid), 32'(m_valid));
            check("serial_out_bits", 32'(serial_out_bits), 32'(m_bits));
            check("grant_id", 32'(grant_id), m_grant);
            check("locked", 32'(locked), 32'(m_locked));
        end
        if (serial_out_valid === 1'b1 && serial_out_ready === 1'b1) begin
            out_b.push_back(serial_out_bits);
            out_g.push_back(int'(grant_id));
            out_t.push_back(cyc);
        end
        lk.push_back(locked);
        rq.push_back(req_ready);
    end

    function automatic int run_from(input int s);
        int n;
        n = 0;
        for (int j = s; j < lk.size(); j++) begin
            if (lk[j] !== 1'b1) break;
            n++;
        end
        return n;
    endfunction

    task automatic check_log(input string name, input string eb, input string eg);
        check({name, ".len"}, out_b.size(), eb.len());
        for (int j = 0; j < eb.len() && j < out_b.size(); j++) begin
            check($sformatf("%s.byte%0d", name, j), 32'(out_b[j]), 32'(eb[j]));
            check($sformatf("%s.grant%0d", name, j), out_g[j], 32'(eg[j] - 8'd48));
        end
    endtask

    // One reset cycle, checks of the reset state, then release with clean logs.
    task automatic do_reset();
        reset = 1'b1;
        cycle();
        chk_en = 1'b1;
        check("rst.valid", 32'(serial_out_valid), 0);
        check("rst.locked", 32'(locked), 0);
        check("rst.grant", 32'(grant_id), 0);
        check("rst.bits", 32'(serial_out_bits), 0);
        check("rst.ready", 32'(req_ready), 0);
        reset = 1'b0;
        out_b.delete(); out_g.delete(); out_t.delete(); lk.delete(); rq.delete();
        drive();
    endtask

    initial begin
        reset = 1'b1;
        serial_out_ready = 1'b1;
        clear_src();
        drive();

        // Two messages contend; the first must finish before the second starts.
        set_src(0, "ab\n");
        set_src(1, "xy\n");
        en = 4'b0011;
        do_reset();
        repeat (12) cycle();
        check_log("msgs", "ab\nxy\n", "000111");

        // Single newlines from everyone rotate the grant one byte per cycle.
        clear_src();
        for (int i = 0; i < N; i++) set_src(i, "\n\n");
        en = 4'b1111;
        do_reset();
        repeat (12) cycle();
        check_log("rotate", "\n\n\n\n\n\n\n\n", "01230123");
        if (out_t.size() == 8) check("rotate.span", out_t[7] - out_t[0], 7);
        else check("rotate.count", out_t.size(), 8);

        // Owner goes quiet: lock drops after TMO idle cycles, pointer moves to 3.
        clear_src();
        set_src(2, "Q");
        set_src(3, "R\n");
        set_src(0, "Z\n");
        en = 4'b1100;
        do_reset();
        cycle();
        cycle();
        en = 4'b1101;
        drive();
        repeat (14) cycle();
        check("timeout.run", run_from(1), 4);
        check("timeout.lk5", (lk.size() > 5) ? 32'(lk[5]) : 32'hdead, 0);
        check("timeout.rq5", (rq.size() > 5) ? 32'(rq[5]) : 32'hdead, 32'h8);
        check_log("timeout", "QR\nZ\n", "23300");

        // Long sink stall with the owner still valid: nothing moves, no timeout.
        clear_src();
        set_src(1, "AB\n");
        en = 4'b0010;
        do_reset();
        cycle();
        serial_out_ready = 1'b0;
        drive();
        repeat (100) cycle();
        check("stall.valid", 32'(serial_out_valid), 1);
        check("stall.bits", 32'(serial_out_bits), 32'h41);
        check("stall.locked", 32'(locked), 1);
        check("stall.ready", 32'(req_ready), 0);
        serial_out_ready = 1'b1;
        repeat (8) cycle();
        check_log("stall", "AB\n", "111");

        // Owner returns exactly when the timer sits at its last value: accept wins.
        clear_src();
        set_src(1, "KL\n");
        en = 4'b0010;
        do_reset();
        cycle();
        en = 4'b0000;
        drive();
        repeat (3) cycle();
        en = 4'b0010;
        drive();
        cycle();
        check("edge.locked", 32'(locked), 1);
        check("edge.bits", 32'(serial_out_bits), 32'h4C);
        repeat (6) cycle();
        check("edge.run", run_from(1), 5);
        check_log("edge", "KL\n", "111");

        // Reset while holding a byte and a lock; restart from the lowest valid index.
        clear_src();
        set_src(2, "MN\n");
        set_src(1, "P\n");
        set_src(3, "S\n");
        en = 4'b0100;
        do_reset();
        cycle();
        serial_out_ready = 1'b0;
        en = 4'b1110;
        drive();
        cycle();
        cycle();
        check("mid.valid", 32'(serial_out_valid), 1);
        check("mid.locked", 32'(locked), 1);
        do_reset();
        check("mid.pos2", src_pos[2], 1);
        check("mid.pos1", src_pos[1], 0);
        serial_out_ready = 1'b1;
        drive();
        repeat (12) cycle();
        check("mid.first", (rq.size() > 0) ? 32'(rq[0]) : 32'hdead, 32'h2);
        check_log("mid", "P\nN\nS\n", "112233");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
